// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst write-traffic generator:
// FSM state encoding and default field widths.
package burst_gen_pkg;

    localparam int unsigned BURST_LEN_W_DEF  = 8;
    localparam int unsigned IDLE_LEN_W_DEF   = 8;
    localparam int unsigned NUM_BURSTS_W_DEF = 8;
    localparam int unsigned CNT_W_DEF        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/burst_wr_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    // Clear has priority; increment stops once every bit is set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/burst_wr_gen.sv
// Burst write-traffic generator driving a FIFO write-enable.
// Optional macro BURST_WR_GEN_DROP_EN: ignore wr_rdy_i backpressure, so
// every BURST cycle writes and miss_cnt_o counts dropped writes.
module burst_wr_gen
    import burst_gen_pkg::*;
#(
    parameter int unsigned BURST_LEN_W  = BURST_LEN_W_DEF,
    parameter int unsigned IDLE_LEN_W   = IDLE_LEN_W_DEF,
    parameter int unsigned NUM_BURSTS_W = NUM_BURSTS_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [BURST_LEN_W-1:0]  burst_len_i,
    input  logic [IDLE_LEN_W-1:0]   idle_len_i,
    input  logic [NUM_BURSTS_W-1:0] num_bursts_i,
    input  logic                    wr_rdy_i,
    output logic                    we_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        wr_cnt_o,
    output logic [CNT_W-1:0]        miss_cnt_o
);

    localparam logic [BURST_LEN_W-1:0]  BL_ONE = BURST_LEN_W'(1);
    localparam logic [IDLE_LEN_W-1:0]   IL_ONE = IDLE_LEN_W'(1);
    localparam logic [NUM_BURSTS_W-1:0] NB_ONE = NUM_BURSTS_W'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BURST_LEN_W-1:0]  r_burst_len;
    logic [IDLE_LEN_W-1:0]   r_idle_len;
    logic [NUM_BURSTS_W-1:0] r_num_bursts;
    logic [BURST_LEN_W-1:0]  r_beat_cnt;
    logic [IDLE_LEN_W-1:0]   r_gap_cnt;
    logic [NUM_BURSTS_W-1:0] r_burst_cnt;

    logic w_start;
    logic w_in_burst;
    logic w_len_nz;
    logic w_we;
    logic w_burst_end;
    logic w_last_burst;
    logic w_gap_end;

    assign w_start    = (r_state == ST_IDLE) && start_i;
    assign w_in_burst = (r_state == ST_BURST);
    assign w_len_nz   = (r_burst_len != '0);

    // A zero-length burst spends one BURST cycle with the write enable low.
`ifdef BURST_WR_GEN_DROP_EN
    assign w_we = w_in_burst && w_len_nz;
`else
    assign w_we = w_in_burst && w_len_nz && wr_rdy_i;
`endif

    // Every asserted write enable is a completed beat in both modes.
    assign w_burst_end  = w_in_burst &&
                          (!w_len_nz || (w_we && (r_beat_cnt == r_burst_len - BL_ONE)));
    assign w_last_burst = (r_burst_cnt == r_num_bursts - NB_ONE);
    assign w_gap_end    = (r_state == ST_GAP) && (r_gap_cnt == r_idle_len - IL_ONE);

    assign we_o   = w_we;
    assign busy_o = (r_state == ST_BURST) || (r_state == ST_GAP);
    assign done_o = (r_state == ST_DONE);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (num_bursts_i == '0) ? ST_DONE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_burst_end) begin
                    if (w_last_burst) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_idle_len == '0) begin
                        w_state_nxt = ST_BURST;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Run parameters latched at start plus beat/gap/burst progress counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_burst_len  <= '0;
            r_idle_len   <= '0;
            r_num_bursts <= '0;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_burst_cnt  <= '0;
        end else if (w_start) begin
            r_burst_len  <= burst_len_i;
            r_idle_len   <= idle_len_i;
            r_num_bursts <= num_bursts_i;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_burst_cnt  <= '0;
        end else if (w_burst_end) begin
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_burst_cnt <= r_burst_cnt + NB_ONE;
        end else if (w_we) begin
            r_beat_cnt <= r_beat_cnt + BL_ONE;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= w_gap_end ? '0 : r_gap_cnt + IL_ONE;
        end
    end

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (w_start),
        .i_inc (w_we && wr_rdy_i),
        .o_cnt (wr_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (w_start),
        .i_inc (w_in_burst && w_len_nz && !wr_rdy_i),
        .o_cnt (miss_cnt_o)
    );

endmodule

// File: tb/tb_burst_wr_gen.sv
// Self-checking bench for burst_wr_gen: behavioural model compared every
// cycle against a default instance and a 3-bit-counter instance, plus
// directed runs with literal expectations.
module tb_burst_wr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] blen = '0;
    logic [7:0] ilen = '0;
    logic [7:0] nb = '0;
    logic       rdy = 1'b1;

    logic        we, busy, done;
    logic [15:0] wr_cnt, miss_cnt;
    logic        we_s, busy_s, done_s;
    logic [2:0]  wr_s, miss_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_wr_gen dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .burst_len_i(blen),
        .idle_len_i(ilen), .num_bursts_i(nb), .wr_rdy_i(rdy),
        .we_o(we), .busy_o(busy), .done_o(done),
        .wr_cnt_o(wr_cnt), .miss_cnt_o(miss_cnt)
    );

    burst_wr_gen #(.CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .burst_len_i(blen),
        .idle_len_i(ilen), .num_bursts_i(nb), .wr_rdy_i(rdy),
        .we_o(we_s), .busy_o(busy_s), .done_o(done_s),
        .wr_cnt_o(wr_s), .miss_cnt_o(miss_s)
    );

`ifdef BURST_WR_GEN_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run described by remaining bursts/beats/gap cycles.
    bit     m_running = 0;
    bit     m_done_now = 0;
    int     m_bursts_left = 0;
    int     m_beats_left = 0;
    int     m_gap_left = 0;
    int     m_L = 0;
    int     m_G = 0;
    longint m_wr = 0;
    longint m_miss = 0;

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_running = 0; m_done_now = 0; m_bursts_left = 0;
            m_beats_left = 0; m_gap_left = 0; m_L = 0; m_G = 0;
            m_wr = 0; m_miss = 0;
            chk("rst_we", we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_wr", wr_cnt, 0);
            chk("rst_miss", miss_cnt, 0);
            chk("rst_wr_s", wr_s, 0);
        end else begin
            bit in_burst;
            bit exp_we;
            in_burst = m_running && (m_gap_left == 0);
            exp_we   = in_burst && (m_L != 0) && (DROP || rdy);
            chk("we", we, exp_we);
            chk("busy", busy, m_running);
            chk("done", done, m_done_now);
            chk("wr_cnt", wr_cnt, sat(m_wr, 65535));
            chk("miss_cnt", miss_cnt, sat(m_miss, 65535));
            chk("we_s", we_s, exp_we);
            chk("busy_s", busy_s, m_running);
            chk("done_s", done_s, m_done_now);
            chk("wr_s", wr_s, sat(m_wr, 7));
            chk("miss_s", miss_s, sat(m_miss, 7));
            // advance to the following cycle
            if (m_done_now) begin
                m_done_now = 0;
            end else if (!m_running) begin
                if (start) begin
                    m_wr = 0; m_miss = 0;
                    m_L = int'(blen); m_G = int'(ilen);
                    if (nb == 0) m_done_now = 1;
                    else begin
                        m_running = 1; m_bursts_left = int'(nb);
                        m_beats_left = m_L; m_gap_left = 0;
                    end
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                bit finished;
                if (m_L != 0 && rdy)  m_wr++;
                if (m_L != 0 && !rdy) m_miss++;
                finished = 0;
                if (m_L == 0) finished = 1;
                else if (exp_we) begin
                    m_beats_left--;
                    if (m_beats_left == 0) finished = 1;
                end
                if (finished) begin
                    m_bursts_left--;
                    if (m_bursts_left == 0) begin
                        m_running = 0; m_done_now = 1;
                    end else begin
                        m_beats_left = m_L; m_gap_left = m_G;
                    end
                end
            end
        end
    end

    // kind: 0 ready high, 1 ready low in cycles 2-3, 2 random ready plus
    // random start/length noise mid-run, 3 ready high with a start pulse
    // and scrambled lengths in cycle 2.
    task automatic run(input int n, input int l, input int g, input int kind,
                       output int dcyc, output int wes, output logic [63:0] pat,
                       output int wr, output int miss, output int wrs);
        dcyc = -1; wes = 0; pat = '0; wr = -1; miss = -1; wrs = -1;
        @(posedge clk); #1;
        start = 1'b1; nb = 8'(n); blen = 8'(l); ilen = 8'(g); rdy = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (kind)
                1: rdy = !(k == 2 || k == 3);
                2: begin
                    rdy   = ($urandom_range(0, 9) < 7);
                    start = ($urandom_range(0, 7) == 0);
                    blen  = 8'($urandom); ilen = 8'($urandom); nb = 8'($urandom);
                end
                3: begin
                    rdy = 1'b1;
                    if (k == 2) begin
                        start = 1'b1; blen = 8'd1; nb = 8'd5; ilen = 8'd9;
                    end
                end
                default: rdy = 1'b1;
            endcase
            @(negedge clk);
            if (k < 64) pat[k] = we;
            if (we) wes++;
            if (done) begin
                dcyc = k; wr = int'(wr_cnt); miss = int'(miss_cnt); wrs = int'(wr_s);
                break;
            end
        end
        if (dcyc < 0) chk("run_timeout", 0, 1);
        @(posedge clk); #1;
        start = 1'b0; rdy = 1'b1;
    endtask

    int dc, wes, wr, miss, wrs;
    logic [63:0] pat;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // N=2 L=4 G=3
        run(2, 4, 3, 0, dc, wes, pat, wr, miss, wrs);
        chk("t1_pattern", pat[15:0], 16'h0F1E);
        chk("t1_done_cyc", dc, 12);
        chk("t1_wr", wr, 8);
        chk("t1_miss", miss, 0);

        // N=1 L=4, two not-ready cycles mid-burst
        run(1, 4, 0, 1, dc, wes, pat, wr, miss, wrs);
        if (DROP) begin
            chk("t2_done_cyc", dc, 5);
            chk("t2_wes", wes, 4);
            chk("t2_wr", wr, 2);
        end else begin
            chk("t2_done_cyc", dc, 7);
            chk("t2_wes", wes, 4);
            chk("t2_wr", wr, 4);
        end
        chk("t2_miss", miss, 2);

        // N=0
        run(0, 4, 2, 0, dc, wes, pat, wr, miss, wrs);
        chk("t3_done_cyc", dc, 1);
        chk("t3_wes", wes, 0);

        // N=3 L=2 G=0
        run(3, 2, 0, 0, dc, wes, pat, wr, miss, wrs);
        chk("t4_pattern", pat[15:0], 16'h007E);
        chk("t4_done_cyc", dc, 7);

        // saturation with a start pulse while busy
        run(1, 12, 0, 3, dc, wes, pat, wr, miss, wrs);
        chk("t5_done_cyc", dc, 13);
        chk("t5_wr", wr, 12);
        chk("t5_wr_sat", wrs, 7);

        // asynchronous reset mid-burst
        @(posedge clk); #1;
        start = 1'b1; nb = 8'd2; blen = 8'd8; ilen = 8'd2; rdy = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t6_we_before", we, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_we_async", we, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_wr_async", wr_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(2, 4, 3, 0, dc, wes, pat, wr, miss, wrs);
        chk("t7_pattern", pat[15:0], 16'h0F1E);
        chk("t7_done_cyc", dc, 12);
        chk("t7_wr", wr, 8);

        // randomized runs
        for (int r = 0; r < 60; r++) begin
            run($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 4), 2,
                dc, wes, pat, wr, miss, wrs);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_wr_gen.md
# burst_wr_gen

Burst write-traffic generator that sits directly upstream of the FIFO under test in the buffer-throughput bench and drives its write-enable. It emits a programmed number of bursts, each of a programmed length, separated by programmed idle gaps, honouring the FIFO's write-ready. It counts accepted writes and missed cycles so the bench can judge whether a given FIFO depth sustains the traffic.

## Interface
- `BURST_LEN_W`, default 8: width of the burst-length and beat counters.
- `IDLE_LEN_W`, default 8: width of the idle-gap length and gap counters.
- `NUM_BURSTS_W`, default 8: width of the burst-count field.
- `CNT_W`, default 16: width of the statistics counters.
---
- `clk_i`  in  1  single clock; the generator and the FIFO write side both run on it.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  starts a run. Sampled only in IDLE.
- `burst_len_i`  in  BURST_LEN_W  beats per burst. Latched at start.
- `idle_len_i`  in  IDLE_LEN_W  idle cycles between bursts. Latched at start.
- `num_bursts_i`  in  NUM_BURSTS_W  bursts per run. Latched at start.
- `wr_rdy_i`  in  1  FIFO write-ready (not full).
- `we_o`  out  1  write enable to the FIFO.
- `busy_o`  out  1  high in BURST and GAP.
- `done_o`  out  1  one-cycle pulse at the end of a run.
- `wr_cnt_o`  out  CNT_W  writes accepted (`we_o & wr_rdy_i`) in the current or last run.
- `miss_cnt_o`  out  CNT_W  burst cycles with `wr_rdy_i` low.

## Operation
- FSM states: IDLE, BURST, GAP, DONE.
- **IDLE**
  - When `start_i` is high, latch the three length inputs, clear both statistics counters and the beat/gap/burst counters.
  - If `num_bursts_i` is 0 → DONE. Otherwise → BURST.
- **BURST**
  - `we_o` is combinational: `we_o = (state==BURST) & wr_rdy_i`. With the drop macro, `we_o = (state==BURST)` instead.
  - A beat completes on an accepted write. In drop mode, every BURST cycle completes a beat.
  - A BURST cycle with `wr_rdy_i` low increments `miss_cnt_o`.
  - After `burst_len` completed beats, increment the burst counter.
    - If it was the last burst → DONE.
    - Else if `idle_len` is 0 → stay in BURST with the beat counter cleared.
    - Else → GAP.
  - A `burst_len` of 0 completes the burst with zero beats, staying one cycle in BURST with `we_o` low.
- **GAP**: `we_o` low; after exactly `idle_len` cycles → BURST.
- **DONE**: `done_o` high for one cycle → IDLE.
- Statistics counters:
  - saturate at all-ones (no wrap);
  - hold their values in IDLE until the next start.
- `start_i` is ignored outside IDLE.
- Length inputs changing mid-run have no effect.

## Timing
- Reset values:
  - state IDLE;
  - `we_o`, `busy_o`, `done_o` = 0;
  - `wr_cnt_o`, `miss_cnt_o` = 0;
  - all internal counters 0.
- `start_i` high at cycle t → BURST at t+1; the first `we_o` can assert at t+1.
- With `wr_rdy_i` constantly high and no macro, a run lasts N·L + (N−1)·G cycles of BURST/GAP, then DONE for one cycle (N bursts, L beats, G gap cycles).
- `done_o` asserts the cycle after the last beat. `busy_o` is low in that cycle.
- Back-to-back runs: a `start_i` held high through DONE is seen in IDLE one cycle later.
- Asserting `rst_i` mid-run immediately (asynchronously) drops `we_o` and returns to IDLE with all counters cleared.

## Configuration
- `BURST_WR_GEN_DROP_EN`
  - **Defined:** the source ignores backpressure. `we_o` is asserted on every BURST cycle, missed cycles still complete beats, and `miss_cnt_o` counts writes the FIFO drops (overflows).
  - **Undefined:** the source stalls on `wr_rdy_i` low. Beats do not advance and `miss_cnt_o` counts stall cycles.

## Structure
- Shared package/header `burst_gen_pkg` holds:
  - the FSM state encodings (2-bit localparams `ST_IDLE`, `ST_BURST`, `ST_GAP`, `ST_DONE`);
  - the default widths.
- One sub-module, `sat_counter`: parameterised width with clear, increment and saturation. It is instantiated twice, for `wr_cnt_o` and `miss_cnt_o`.

## Test plan
- N=2, L=4, G=3, `wr_rdy_i`=1 → `we_o` pattern 1111 000 1111, `done_o` at cycle 12 after start, `wr_cnt_o`=8, `miss_cnt_o`=0.
- N=1, L=4, `wr_rdy_i` low for 2 cycles mid-burst (no macro) → burst stretches to 6 cycles, `wr_cnt_o`=4, `miss_cnt_o`=2.
- Same stimulus with `BURST_WR_GEN_DROP_EN` → burst lasts 4 cycles, `we_o` high 4 cycles, `wr_cnt_o`=2, `miss_cnt_o`=2.
- Edge lengths:
  - N=0 → `done_o` pulse at t+1 and `we_o` never high.
  - N=3, L=2, G=0 → 6 consecutive `we_o` cycles.
- `rst_i` asserted mid-BURST → `we_o`=0 immediately, IDLE, counters 0. A subsequent start runs normally.
- CNT_W=3, N=1, L=12 → `wr_cnt_o` saturates at 7. `start_i` pulsed while busy is ignored.
